boot_rom_reader: RTL and testbench

BOOT_ROM_READER -- requirements
Module: boot_rom_reader

---
 rtl/boot_rom_reader.sv | 207 ++++++++++++++++++++
 tb/tb_boot_rom_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_reader.sv
// Sequential boot-ROM reader: issues in-order reads on a req/gnt bus and streams
// the returned words through a credit-limited FIFO. Define BOOT_ROM_READER_CSUM_EN to add csum_o.
module boot_rom_reader #(
    parameter int DATA_WIDTH = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [31:0]           base_addr_i,
    input  logic [15:0]           num_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  req_o,
    output logic [31:0]           add_o,
    output logic                  wen_o,
    input  logic                  gnt_i,
    input  logic                  r_valid_i,
    input  logic [DATA_WIDTH-1:0] r_rdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
`ifdef BOOT_ROM_READER_CSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] csum_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [15:0]     num_q, num_d;
    logic [15:0]     issued_q, issued_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            done_q, done_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic            last_issue;
    logic [CW:0]     inflight;
    logic            credit_ok;

    // Words requested but not yet popped never exceed the FIFO depth, so a
    // granted read always has a free slot waiting for its response.
    assign inflight   = {1'b0, outst_q} + {1'b0, cnt_q};
    assign credit_ok  = (inflight < DEPTH_W);
    assign last_issue = (({1'b0, issued_q} + 17'd1) == {1'b0, num_q});

    always_comb begin : p_handshake
        issue = req_o & gnt_i;
        push  = r_valid_i & (outst_q != '0);
        pop   = valid_o & ready_i;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            num_q    <= '0;
            issued_q <= '0;
            outst_q  <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= r_rdata_i;
        end
    end

    // Next-state logic
    always_comb begin : p_next
        state_d  = state_q;
        addr_d   = addr_q;
        num_d    = num_q;
        issued_d = issued_q;
        outst_d  = outst_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = 1'b0;

        if (issue && !push) begin
            outst_d = outst_q + CW'(1);
        end else if (!issue && push) begin
            outst_d = outst_q - CW'(1);
        end

        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (issue) begin
            addr_d   = addr_q + 32'd4;
            issued_d = issued_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d   = base_addr_i;
                    num_d    = num_words_i;
                    issued_d = '0;
                    if (num_words_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (issue && last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((outst_d == '0) && (cnt_d == '0)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin : p_out
        busy_o  = (state_q != ST_IDLE);
        done_o  = done_q;
        req_o   = (state_q == ST_FETCH) && (issued_q < num_q) && credit_ok;
        add_o   = addr_q;
        wen_o   = 1'b1;
        valid_o = (cnt_q != '0);
        data_o  = mem_q[rd_ptr_q];
    end

`ifdef BOOT_ROM_READER_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;

    always_comb begin : p_csum
        csum_d = csum_q;
        if ((state_q == ST_IDLE) && start_i) begin
            csum_d = '0;
        end else if (pop) begin
            csum_d = csum_q + data_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;
`endif

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (cnt_q == CW'(FIFO_DEPTH))));

    a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_o && !gnt_i) |=> (req_o && $stable(add_o)));

endmodule

// File: tb/tb_boot_rom_reader.sv
// Scoreboard bench for boot_rom_reader: stimulus queues expected grants/words,
// a negedge monitor checks every grant and stream pop against them.
`timescale 1ns/1ps
module tb_boot_rom_reader;
    localparam int DW = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, start_i, busy_o, done_o, req_o, wen_o;
    logic          gnt_i, r_valid_i, valid_o, ready_i;
    logic [31:0]   base_addr_i, add_o;
    logic [15:0]   num_words_i;
    logic [DW-1:0] r_rdata_i, data_o;
`ifdef BOOT_ROM_READER_CSUM_EN
    logic [DW-1:0] csum_o;
    logic [DW-1:0] csum_at_done;
`endif

    logic gnt_en;
    assign gnt_i = req_o & gnt_en;

    boot_rom_reader #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .num_words_i(num_words_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .req_o      (req_o),
        .add_o      (add_o),
        .wen_o      (wen_o),
        .gnt_i      (gnt_i),
        .r_valid_i  (r_valid_i),
        .r_rdata_i  (r_rdata_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
`ifdef BOOT_ROM_READER_CSUM_EN
        ,
        .csum_o     (csum_o)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    logic [31:0]   exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    resp_t         resp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int resp_lat = 1;
    bit rom_mode = 1'b0;
    int done_cnt = 0;
    int done_cyc = -1;
    int grant_cnt = 0;
    int first_req_cyc = -1;
    int first_valid_cyc = -1;
    bit busy_seen = 1'b0;
    bit valid_seen = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_add = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rom_word(input logic [31:0] a);
        logic [DW-1:0] w;
        if (rom_mode) begin
            case (a[3:2])
                2'd0:    w = 40'd1;
                2'd1:    w = 40'd2;
                2'd2:    w = 40'd3;
                default: w = 40'hFF_FFFF_FFFF;
            endcase
        end else begin
            w = {8'hC3, a};
        end
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Read-response model: fixed latency, in order
    initial begin
        r_valid_i = 1'b0;
        r_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                r_valid_i = 1'b1;
                r_rdata_i = resp_q[0].data;
                resp_q.delete(0);
            end else begin
                r_valid_i = 1'b0;
                r_rdata_i = '0;
            end
        end
    end

    // Monitor / scoreboard
    initial forever begin
        resp_t r;
        @(negedge clk);
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("req_held", 64'(req_o), 64'd1);
                chk("addr_held", 64'(add_o), 64'(prev_add));
            end
            prev_stall = req_o && !gnt_i;
            prev_add   = add_o;
            if (busy_o) busy_seen = 1'b1;
            if (valid_o) begin
                valid_seen = 1'b1;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (req_o && first_req_cyc < 0) first_req_cyc = cyc;
            if (req_o && gnt_i) begin
                grant_cnt++;
                $display("[cyc %0d] grant addr=0x%08h", cyc, add_o);
                if (exp_addr_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got addr 0x%08h, required no grant", add_o);
                end else begin
                    chk("grant_addr", 64'(add_o), 64'(exp_addr_q.pop_front()));
                end
                r.data = rom_word(add_o);
                r.due  = cyc + resp_lat;
                resp_q.push_back(r);
            end
            if (valid_o && ready_i) begin
                $display("[cyc %0d] pop data=0x%010h", cyc, data_o);
                if (exp_data_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%010h, required no word", data_o);
                end else begin
                    chk("stream_data", 64'(data_o), 64'(exp_data_q.pop_front()));
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                $display("[cyc %0d] done", cyc);
`ifdef BOOT_ROM_READER_CSUM_EN
                csum_at_done = csum_o;
`endif
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [31:0] base, input logic [15:0] n, output int t0);
        start_i         = 1'b1;
        base_addr_i     = base;
        num_words_i     = n;
        t0              = cyc;
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        busy_seen       = 1'b0;
        valid_seen      = 1'b0;
        next_cycle();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound, input bit toggle_ready);
        int i = 0;
        while (done_cnt == d0 && i < bound) begin
            if (toggle_ready) ready_i = ~ready_i;
            next_cycle();
            i++;
        end
        ready_i = 1'b1;
        chk("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic expect_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(base + 32'(4 * i));
            exp_data_q.push_back(rom_word(base + 32'(4 * i)));
        end
    endtask

    initial begin
        int t0, d0, g0;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        base_addr_i = '0;
        num_words_i = '0;
        ready_i     = 1'b1;
        gnt_en      = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_req", 64'(req_o), 64'd0);
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_addr", 64'(add_o), 64'd0);
        chk("wen_read", 64'(wen_o), 64'd1);
`ifdef BOOT_ROM_READER_CSUM_EN
        chk("reset_csum", 64'(csum_o), 64'd0);
`endif
        next_cycle();
        rst_i = 1'b0;
        next_cycle();

        // Basic 4-word transfer, minimum latency
        d0 = done_cnt;
        exp_addr_q.push_back(32'h1A00_0000); exp_data_q.push_back(40'hC3_1A00_0000);
        exp_addr_q.push_back(32'h1A00_0004); exp_data_q.push_back(40'hC3_1A00_0004);
        exp_addr_q.push_back(32'h1A00_0008); exp_data_q.push_back(40'hC3_1A00_0008);
        exp_addr_q.push_back(32'h1A00_000C); exp_data_q.push_back(40'hC3_1A00_000C);
        start_xfer(32'h1A00_0000, 16'd4, t0);
        @(negedge clk);
        chk("t1_busy", 64'(busy_o), 64'd1);
        chk("t1_req", 64'(req_o), 64'd1);
        chk("t1_first_addr", 64'(add_o), 64'h1A00_0000);
        wait_done(d0, 40, 1'b0);
        chk("t1_done_cycle", 64'(done_cyc - t0), 64'd7);
        chk("t1_req_cycle", 64'(first_req_cyc - t0), 64'd1);
        chk("t1_valid_cycle", 64'(first_valid_cyc - t0), 64'd3);
        chk("t1_busy_after", 64'(busy_o), 64'd0);
        chk("t1_words_left", 64'(exp_data_q.size()), 64'd0);
        chk("t1_grants_left", 64'(exp_addr_q.size()), 64'd0);

        // Zero-length transfer
        d0 = done_cnt;
        g0 = grant_cnt;
        start_xfer(32'h4000_0000, 16'd0, t0);
        wait_done(d0, 10, 1'b0);
        chk("t2_done_cycle", 64'(done_cyc - t0), 64'd1);
        chk("t2_no_req", 64'(first_req_cyc), 64'(-1));
        chk("t2_busy_seen", 64'(busy_seen), 64'd0);
        chk("t2_grants", 64'(grant_cnt - g0), 64'd0);

        // 16 words with the stream stalled: credit limit caps grants at 4
        resp_lat = 2;
        ready_i  = 1'b0;
        d0 = done_cnt;
        g0 = grant_cnt;
        expect_seq(32'h0000_1000, 16);
        start_xfer(32'h0000_1000, 16'd16, t0);
        repeat (19) next_cycle();
        chk("t3_grants_stalled", 64'(grant_cnt - g0), 64'd4);
        chk("t3_valid_stalled", 64'(valid_o), 64'd1);
        ready_i = 1'b1;
        wait_done(d0, 200, 1'b0);
        chk("t3_grants_total", 64'(grant_cnt - g0), 64'd16);
        chk("t3_words_left", 64'(exp_data_q.size()), 64'd0);

        // Grant withheld 3 cycles, address wraps past 2^32
        resp_lat = 1;
        gnt_en   = 1'b0;
        d0 = done_cnt;
        g0 = grant_cnt;
        exp_addr_q.push_back(32'hFFFF_FFFC); exp_data_q.push_back(40'hC3_FFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000); exp_data_q.push_back(40'hC3_0000_0000);
        start_xfer(32'hFFFF_FFFC, 16'd2, t0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("t4_req_waiting", 64'(req_o), 64'd1);
        chk("t4_addr_waiting", 64'(add_o), 64'hFFFF_FFFC);
        chk("t4_no_grant", 64'(grant_cnt - g0), 64'd0);
        next_cycle();
        gnt_en = 1'b1;
        wait_done(d0, 20, 1'b0);
        chk("t4_words_left", 64'(exp_data_q.size()), 64'd0);

        // Reset with two reads outstanding; late responses must be dropped
        resp_lat = 5;
        d0 = done_cnt;
        exp_addr_q.push_back(32'h0000_2000);
        exp_addr_q.push_back(32'h0000_2004);
        start_xfer(32'h0000_2000, 16'd4, t0);
        next_cycle();
        next_cycle();
        gnt_en = 1'b0;
        rst_i  = 1'b1;
        next_cycle();
        rst_i      = 1'b0;
        gnt_en     = 1'b1;
        valid_seen = 1'b0;
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_req", 64'(req_o), 64'd0);
        chk("t5_valid", 64'(valid_o), 64'd0);
        chk("t5_addr", 64'(add_o), 64'd0);
        repeat (8) next_cycle();
        chk("t5_late_dropped", 64'(valid_seen), 64'd0);
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t5_grants_left", 64'(exp_addr_q.size()), 64'd0);

        // Recovery transfer with a toggling stream ready
        resp_lat = 3;
        d0 = done_cnt;
        expect_seq(32'h3000_0010, 3);
        start_xfer(32'h3000_0010, 16'd3, t0);
        wait_done(d0, 60, 1'b1);
        chk("t6_words_left", 64'(exp_data_q.size()), 64'd0);

`ifdef BOOT_ROM_READER_CSUM_EN
        // Checksum wraps modulo 2^40
        resp_lat = 1;
        rom_mode = 1'b1;
        d0 = done_cnt;
        exp_addr_q.push_back(32'h0); exp_data_q.push_back(40'd1);
        exp_addr_q.push_back(32'h4); exp_data_q.push_back(40'd2);
        exp_addr_q.push_back(32'h8); exp_data_q.push_back(40'd3);
        exp_addr_q.push_back(32'hC); exp_data_q.push_back(40'hFF_FFFF_FFFF);
        start_xfer(32'h0, 16'd4, t0);
        chk("t7_csum_cleared", 64'(csum_o), 64'd0);
        wait_done(d0, 40, 1'b0);
        chk("t7_csum_at_done", 64'(csum_at_done), 64'h5);
        repeat (3) next_cycle();
        chk("t7_csum_held", 64'(csum_o), 64'h5);
        rom_mode = 1'b0;
`endif

        repeat (2) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

endmodule
